apb_requester: RTL

APB4 requester (master) that turns a simple valid/ready command stream into APB transfers and returns read data and error status on a valid/ready response stream. It drives the same `s_apb_*` slave port that register-block DUTs expose. It is the bench and bridge-side counterpart used to exercise generated register blocks from native RTL, without a bus-functional model.

---
 rtl/apb_requester_pkg.sv | 30 +++
 rtl/apb_requester_timer.sv | 31 +++
 rtl/apb_requester.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/apb_requester_pkg.sv
// Shared types and default widths for the APB4 requester and its timeout timer.
package apb_requester_pkg;

    localparam int APB_REGWIDTH       = 32;
    localparam int APB_ADDR_WIDTH     = 8;
    localparam int APB_STRB_WIDTH     = APB_REGWIDTH / 8;
    localparam int APB_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        APB_REQ_IDLE   = 2'd0,
        APB_REQ_SETUP  = 2'd1,
        APB_REQ_ACCESS = 2'd2,
        APB_REQ_RESP   = 2'd3
    } apb_req_state_e;

    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_REGWIDTH-1:0]   wdata;
        logic [APB_STRB_WIDTH-1:0] strb;
        logic [2:0]                prot;
    } apb_req_cmd_t;

    typedef struct packed {
        logic [APB_REGWIDTH-1:0] rdata;
        logic                    slverr;
        logic                    timeout;
    } apb_req_rsp_t;

endpackage

// File: rtl/apb_requester_timer.sv
// Loadable down-counter that flags when it has reached zero; used to bound the
// APB ACCESS phase when APB_REQUESTER_TIMEOUT_EN is defined.
module apb_requester_timer
    import apb_requester_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Counting saturates at zero so a stalled enable cannot wrap the flag away.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: one command at a time from a valid/ready stream to an APB
// transfer and back to a response stream. Optional ACCESS timeout: APB_REQUESTER_TIMEOUT_EN.
module apb_requester
    import apb_requester_pkg::*;
#(
    parameter int REGWIDTH       = APB_REGWIDTH,
    parameter int G_ADDR_WIDTH   = APB_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [G_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [REGWIDTH-1:0]     cmd_wdata,
    input  logic [REGWIDTH/8-1:0]   cmd_strb,
    input  logic [2:0]              cmd_prot,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [REGWIDTH-1:0]     rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,

    output logic                    m_apb_psel,
    output logic                    m_apb_penable,
    output logic                    m_apb_pwrite,
    output logic [2:0]              m_apb_pprot,
    output logic [G_ADDR_WIDTH-1:0] m_apb_paddr,
    output logic [REGWIDTH-1:0]     m_apb_pwdata,
    output logic [REGWIDTH/8-1:0]   m_apb_pstrb,
    input  logic                    m_apb_pready,
    input  logic                    m_apb_pslverr,
    input  logic [REGWIDTH-1:0]     m_apb_prdata
);

    localparam logic [1:0] ST_IDLE   = APB_REQ_IDLE;
    localparam logic [1:0] ST_SETUP  = APB_REQ_SETUP;
    localparam logic [1:0] ST_ACCESS = APB_REQ_ACCESS;
    localparam logic [1:0] ST_RESP   = APB_REQ_RESP;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       ready_q;
    logic       accept;
    logic       access_done;
    logic       timeout_hit;

    assign accept      = (state == ST_IDLE) && cmd_valid && ready_q;
    assign access_done = (state == ST_ACCESS) && m_apb_pready;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (access_done || timeout_hit) state_next = ST_RESP;
            ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // cmd_ready is registered so it stays low throughout reset and rises one
    // cycle after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_apb_pwrite <= 1'b0;
            m_apb_pprot  <= '0;
            m_apb_paddr  <= '0;
            m_apb_pwdata <= '0;
            m_apb_pstrb  <= '0;
        end else if (accept) begin
            m_apb_pwrite <= cmd_write;
            m_apb_pprot  <= cmd_prot;
            m_apb_paddr  <= cmd_addr;
            m_apb_pwdata <= cmd_write ? cmd_wdata : '0;
            m_apb_pstrb  <= cmd_write ? cmd_strb : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else if (access_done) begin
            rsp_rdata  <= m_apb_pwrite ? '0 : m_apb_prdata;
            rsp_slverr <= m_apb_pslverr;
        end else if (timeout_hit) begin
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b1;
        end
    end

`ifdef APB_REQUESTER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    logic tmr_load;
    logic tmr_enable;
    logic tmr_expired;

    assign tmr_load    = (state == ST_SETUP);
    assign tmr_enable  = (state == ST_ACCESS);
    // Expiry marks the last allowed ACCESS cycle; pready there still wins.
    assign timeout_hit = (state == ST_ACCESS) && tmr_expired && !m_apb_pready;

    apb_requester_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .load_value(TMR_W'(TIMEOUT_CYCLES - 1)),
        .enable    (tmr_enable),
        .expired   (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_timeout <= 1'b0;
        end else if (access_done) begin
            rsp_timeout <= 1'b0;
        end else if (timeout_hit) begin
            rsp_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready     = ready_q;
    assign rsp_valid     = (state == ST_RESP);
    assign m_apb_psel    = (state == ST_SETUP) || (state == ST_ACCESS);
    assign m_apb_penable = (state == ST_ACCESS);

endmodule
